// File: rtl/sprite_motion_ctrl.sv
// Tile-map platformer motion engine: per-tick horizontal step, vertical physics
// with four-sided tile collision, then the idle/walk/jump animation sequencer.
module sprite_motion_ctrl #(
  parameter int TILE_SHIFT  = 5,
  parameter int MAP_W       = 20,
  parameter int MAP_H       = 15,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480,
  parameter int X_STEP      = 5,
  parameter int JUMP_V0     = 12,
  parameter int GRAV        = 1,
  parameter int VMAX        = 12,
  parameter int IDLE_FRAMES = 4,
  parameter int WALK_FRAMES = 6,
  parameter int JUMP_FRAMES = 8,
  parameter int ANIM_DIV    = 4,
  parameter int X0          = 0,
  parameter int Y0          = 416
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   left,
  input  logic                   right,
  input  logic                   jump,
  input  logic [MAP_W*MAP_H-1:0] map_bits,
  output logic [9:0]             pos_x,
  output logic [9:0]             pos_y,
  output logic                   face_left,
  output logic                   on_ground,
  output logic [1:0]             anim_sel,
  output logic [3:0]             frame_idx,
  output logic                   busy,
  output logic                   upd_done
);

  localparam int IW = $clog2(MAP_W * MAP_H);
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  if (X_STEP >= (1 << TILE_SHIFT) || VMAX >= (1 << TILE_SHIFT)) begin : g_tunnel_err
    $error("X_STEP and VMAX must be smaller than one tile");
  end
  if (IDLE_FRAMES > 16 || WALK_FRAMES > 16 || JUMP_FRAMES > 16) begin : g_frame_err
    $error("animation frame counts must not exceed 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_H, S_V, S_A} state_t;

  state_t            state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic              face_left_q, face_left_d, on_ground_q, on_ground_d;
  logic [1:0]        anim_sel_q, anim_sel_d;
  logic [3:0]        frame_idx_q, frame_idx_d;
  logic              upd_done_q, upd_done_d;
  logic signed [7:0] vy_q, vy_d;
  logic              jump_armed_q, jump_armed_d, moving_q, moving_d;
  logic [DW-1:0]     div_q, div_d;
  logic              left_q, left_d, right_q, right_d, jump_q, jump_d;

  // Anything outside the map counts as solid, which also gives the screen floor.
  function automatic logic is_solid(input int col, input int row);
    logic [IW-1:0] idx;
    idx = '0;
    if (col < 0 || row < 0 || col >= MAP_W || row >= MAP_H) return 1'b1;
    idx = IW'(row * MAP_W + col);
    return map_bits[idx];
  endfunction

  int dx, x_cand, x_new, h_col, h_row_t, h_row_b;

  always_comb begin
    dx = 0;
    if (right_q && !left_q)      dx = X_STEP;
    else if (left_q && !right_q) dx = -X_STEP;
    x_cand = int'(pos_x_q) + dx;
    if (x_cand < 0)                  x_cand = 0;
    else if (x_cand > SCR_W - SPR_W) x_cand = SCR_W - SPR_W;
    h_row_t = int'(pos_y_q) >>> TILE_SHIFT;
    h_row_b = (int'(pos_y_q) + SPR_H - 1) >>> TILE_SHIFT;
    h_col   = (dx > 0) ? ((x_cand + SPR_W - 1) >>> TILE_SHIFT) : (x_cand >>> TILE_SHIFT);
    x_new   = x_cand;
    if (dx != 0 && (is_solid(h_col, h_row_t) || is_solid(h_col, h_row_b)))
      x_new = (dx > 0) ? ((h_col << TILE_SHIFT) - SPR_W) : ((h_col + 1) << TILE_SHIFT);
  end

  int   vy_n, y_new, v_col_l, v_col_r, v_row, s_row;
  logic armed_n, og_n;

  always_comb begin
    armed_n = jump_armed_q;
    vy_n    = int'(vy_q);
    if (on_ground_q && jump_q && jump_armed_q) begin
      vy_n    = -JUMP_V0;
      armed_n = 1'b0;
    end else if (!on_ground_q) begin
      vy_n = (int'(vy_q) + GRAV > VMAX) ? VMAX : int'(vy_q) + GRAV;
    end
    if (!jump_q) armed_n = 1'b1;
    y_new   = int'(pos_y_q) + vy_n;
    v_col_l = int'(pos_x_q) >>> TILE_SHIFT;
    v_col_r = (int'(pos_x_q) + SPR_W - 1) >>> TILE_SHIFT;
    v_row   = 0;
    if (vy_n < 0) begin
      if (y_new < 0) begin
        y_new = 0;
        vy_n  = 0;
      end else begin
        v_row = y_new >>> TILE_SHIFT;
        if (is_solid(v_col_l, v_row) || is_solid(v_col_r, v_row)) begin
          y_new = (v_row + 1) << TILE_SHIFT;
          vy_n  = 0;
        end
      end
    end else begin
      v_row = (y_new + SPR_H - 1) >>> TILE_SHIFT;
      if (is_solid(v_col_l, v_row) || is_solid(v_col_r, v_row))
        y_new = (v_row << TILE_SHIFT) - SPR_H;
    end
    // Support probe one pixel below the sprite decides grounded vs falling.
    s_row = (y_new + SPR_H) >>> TILE_SHIFT;
    og_n  = is_solid(v_col_l, s_row) || is_solid(v_col_r, s_row);
    if (og_n) vy_n = 0;
  end

  logic [1:0] sel;
  int         nframes;

  always_comb begin
    sel = !on_ground_q ? 2'd2 : (moving_q ? 2'd1 : 2'd0);
    case (sel)
      2'd1:    nframes = WALK_FRAMES;
      2'd2:    nframes = JUMP_FRAMES;
      default: nframes = IDLE_FRAMES;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    face_left_d  = face_left_q;
    on_ground_d  = on_ground_q;
    anim_sel_d   = anim_sel_q;
    frame_idx_d  = frame_idx_q;
    vy_d         = vy_q;
    jump_armed_d = jump_armed_q;
    moving_d     = moving_q;
    div_d        = div_q;
    left_d       = left_q;
    right_d      = right_q;
    jump_d       = jump_q;
    upd_done_d   = (state_q == S_A);
    case (state_q)
      S_IDLE: if (tick) begin
        left_d  = left;
        right_d = right;
        jump_d  = jump;
        state_d = S_H;
      end
      S_H: begin
        pos_x_d  = 10'(x_new);
        moving_d = (dx != 0);
        if (dx > 0)      face_left_d = 1'b0;
        else if (dx < 0) face_left_d = 1'b1;
        state_d = S_V;
      end
      S_V: begin
        pos_y_d      = 10'(y_new);
        vy_d         = 8'(vy_n);
        on_ground_d  = og_n;
        jump_armed_d = armed_n;
        state_d      = S_A;
      end
      S_A: begin
        anim_sel_d = sel;
        if (sel != anim_sel_q) begin
          frame_idx_d = 4'd0;
          div_d       = '0;
        end else if (div_q == DW'(ANIM_DIV - 1)) begin
          div_d       = '0;
          frame_idx_d = (int'(frame_idx_q) >= nframes - 1) ? 4'd0 : frame_idx_q + 4'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pos_x_q      <= 10'(X0);
      pos_y_q      <= 10'(Y0);
      face_left_q  <= 1'b0;
      on_ground_q  <= 1'b1;
      anim_sel_q   <= 2'd0;
      frame_idx_q  <= 4'd0;
      upd_done_q   <= 1'b0;
      vy_q         <= 8'sd0;
      jump_armed_q <= 1'b1;
      moving_q     <= 1'b0;
      div_q        <= '0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      jump_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      face_left_q  <= face_left_d;
      on_ground_q  <= on_ground_d;
      anim_sel_q   <= anim_sel_d;
      frame_idx_q  <= frame_idx_d;
      upd_done_q   <= upd_done_d;
      vy_q         <= vy_d;
      jump_armed_q <= jump_armed_d;
      moving_q     <= moving_d;
      div_q        <= div_d;
      left_q       <= left_d;
      right_q      <= right_d;
      jump_q       <= jump_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign face_left = face_left_q;
  assign on_ground = on_ground_q;
  assign anim_sel  = anim_sel_q;
  assign frame_idx = frame_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign upd_done  = upd_done_q;

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Parametrised player-motion engine for the tile-map platformer.
- Integer per-tick position/velocity physics with tile-map collision on all four sides: walls, ceilings, landing, and walking off ledges.
- Also runs the idle/walk/jump animation sequencer.
- Sits between joystick decode (left/right/jump levels, plus a tick pulse) and the VGA sprite address generator, which consumes pos_x/pos_y/face_left/anim_sel/frame_idx.

Parameters:
- TILE_SHIFT, 5: tile size is 2^TILE_SHIFT pixels.
- MAP_W, 20: map columns.
- MAP_H, 15: map rows.
- SPR_W, 32: sprite width in px.
- SPR_H, 32: sprite height in px.
- SCR_W, 640: screen width in px.
- SCR_H, 480: screen height in px.
- X_STEP, 5: horizontal px per tick. Must be < 2^TILE_SHIFT.
- JUMP_V0, 12: initial upward speed in px/tick.
- GRAV, 1: vy increment per tick while airborne.
- VMAX, 12: max fall speed. Must be < 2^TILE_SHIFT.
- IDLE_FRAMES, 4: idle animation length.
- WALK_FRAMES, 6: walk animation length.
- JUMP_FRAMES, 8: jump animation length.
- ANIM_DIV, 4: ticks per animation frame.
- X0, 0: reset x position.
- Y0, 416: reset y position.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- tick, in, 1: one-cycle physics-step strobe.
- left, in, 1: move-left request (level).
- right, in, 1: move-right request (level).
- jump, in, 1: jump button (level).
- map_bits, in, MAP_W*MAP_H: 1 = solid. Bit index is row*MAP_W+col; col 0 is leftmost.
- pos_x, out, 10: sprite top-left x.
- pos_y, out, 10: sprite top-left y.
- face_left, out, 1: facing direction.
- on_ground, out, 1: standing on a solid tile or the screen floor.
- anim_sel, out, 2: 0 = idle, 1 = walk, 2 = jump.
- frame_idx, out, 4: current animation frame.
- busy, out, 1: an update is in progress.
- upd_done, out, 1: one-cycle pulse when all outputs are updated.

Behaviour:
- Reset (rst=0, asynchronous): every output is forced immediately to its reset value.
  - pos_x=X0, pos_y=Y0, on_ground=1, face_left=0, anim_sel=0, frame_idx=0, busy=0, upd_done=0.
  - Internal state: vy=0, anim counter=0, jump_armed=1, FSM=S_IDLE.
  - Any in-flight update is discarded. No upd_done is produced for it.
- Solid test: a tile at (col,row) is solid if col>=MAP_W, row>=MAP_H, or its map_bits bit is set.
- Coordinate tests: negative coordinates are handled by explicit compare, never by wrap.
- FSM states: S_IDLE -> S_H -> S_V -> S_A -> S_IDLE, one cycle each.
  - tick is accepted only in S_IDLE.
  - busy=1 in S_H, S_V and S_A.
  - A tick arriving while busy is dropped.
  - upd_done is registered high for the cycle after S_A, i.e. 4 cycles after the accepting edge.
- S_H (horizontal step):
  - Direction: right&!left gives +X_STEP; left&!right gives -X_STEP. Both or neither gives no move and moving=0.
  - face_left updates to the requested direction even when the move is blocked.
  - Candidate x' is clamped to [0, SCR_W-SPR_W].
  - Probe the leading-edge column at the top row (y) and bottom row (y+SPR_H-1).
  - If either probe is solid, snap: moving right gives x'=(col<<TILE_SHIFT)-SPR_W; moving left gives x'=(col+1)<<TILE_SHIFT.
- S_V (vertical step):
  - vy is signed 8-bit.
  - Jump start: if on_ground and jump and jump_armed, then vy=-JUMP_V0, jump_armed=0.
  - Otherwise, if !on_ground, vy=min(vy+GRAV, VMAX).
  - jump_armed is set to 1 on any tick where jump=0. A held button never re-jumps.
  - Candidate: y'=y+vy.
  - vy<0 (rising): if y'<0, or the row of y' is solid at either corner column (x, x+SPR_W-1), snap y'=(row+1)<<TILE_SHIFT (0 if y'<0) and set vy=0.
  - vy>=0 (falling): if the row of y'+SPR_H-1 is solid at either corner, snap y'=(row<<TILE_SHIFT)-SPR_H.
  - Support probe at row of y'+SPR_H, at both corners (rows >= MAP_H count as solid):
    - Solid gives on_ground=1, vy=0.
    - Free gives on_ground=0, so walking off a ledge starts a fall on the next tick.
- S_A (animation):
  - sel = 2 if !on_ground; else 1 if moving; else 0.
  - If sel differs from anim_sel: frame_idx=0 and div counter=0.
  - Otherwise div counter increments. On reaching ANIM_DIV-1 it wraps to 0 and frame_idx advances modulo the frame count of sel.
- Elaboration:
  - Error if X_STEP or VMAX >= 2^TILE_SHIFT (tunnelling guard).
  - Error if the frame counts exceed 16.

Test Plan:
- Idle: reset; only row 14 solid; no input; 8 ticks spaced 10 cycles -> pos stays (0,416), on_ground=1, anim_sel=0, frame_idx 1 after tick 4 and 2 after tick 8, upd_done exactly 4 cycles after each tick.
- Walk: right held 3 ticks -> pos_x 5,10,15; face_left=0; anim_sel=1, frame_idx=0. Then left 1 tick -> pos_x=10, face_left=1.
- Wall: tile (col2,row13) solid; right held -> pos_x 5..30, then snap to 32 and stays 32; face_left=0.
- Jump arc: jump held from rest -> y 404,393,…,338 (apex at tick 12-13); lands at tick 25 with y=416, on_ground=1, anim_sel=0→jump(2)→idle. Still-held jump causes no re-jump; release then press jumps again.
- Ceiling: tile (col0,row11) solid; jump -> y 404,393, then snap to 384 with vy=0; then falls and lands at 416.
- Control: two ticks on consecutive cycles -> exactly one update. rst=0 asserted during S_V -> outputs at reset values immediately, busy=0, no upd_done pulse.
